// File: rtl/cxu_types.sv
// Shared CXU interface widths, function codes and response status codes.
package cxu_types;

  localparam int C_M_CXU_REQ_ID_W   = 3;
  localparam int C_M_CXU_CXU_ID_W   = 4;
  localparam int C_M_CXU_STATE_ID_W = 3;
  localparam int C_M_CXU_FUNC_ID_W  = 3;
  localparam int C_M_CXU_INSN_W     = 32;
  localparam int C_M_CXU_DATA_W     = 32;
  localparam int C_M_CXU_STATUS_W   = 3;

  localparam logic [C_M_CXU_FUNC_ID_W-1:0] CXU_FUNC_ADD    = 3'd0;
  localparam logic [C_M_CXU_FUNC_ID_W-1:0] CXU_FUNC_MUL    = 3'd1;
  localparam logic [C_M_CXU_FUNC_ID_W-1:0] CXU_FUNC_MAC    = 3'd2;
  localparam logic [C_M_CXU_FUNC_ID_W-1:0] CXU_FUNC_RDACC  = 3'd3;
  localparam logic [C_M_CXU_FUNC_ID_W-1:0] CXU_FUNC_CLRACC = 3'd4;

  localparam logic [C_M_CXU_STATUS_W-1:0] CXU_STATUS_OK  = 3'd0;
  localparam logic [C_M_CXU_STATUS_W-1:0] CXU_STATUS_ERR = 3'd1;

  // Functions that address an accumulator context.
  function automatic logic uses_acc(input logic [C_M_CXU_FUNC_ID_W-1:0] func);
    return (func == CXU_FUNC_MAC) || (func == CXU_FUNC_RDACC) || (func == CXU_FUNC_CLRACC);
  endfunction

endpackage

// File: rtl/cxu_serial_mul.sv
// Radix-2 shift-add multiplier: one multiplier bit per cycle, always W cycles.
module cxu_serial_mul #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] product
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]     mcand_reg;
  logic [W-1:0]     mplier_reg;
  logic [W-1:0]     acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic [W-1:0]     step_sum;

  // Partial sum including the current multiplier bit; on the last step this is the product.
  assign step_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign done     = busy_reg && (cnt_reg == CNT_W'(W - 1));
  assign product  = step_sum;

  // Load operands on start, then consume one multiplier bit per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else if (start) begin
      mcand_reg  <= a;
      mplier_reg <= b;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      acc_reg    <= step_sum;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      if (cnt_reg == CNT_W'(W - 1)) begin
        busy_reg <= 1'b0;
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cxu_mac_unit.sv
// CXU multiply/accumulate unit with per-context accumulators and an iterative multiplier.
module cxu_mac_unit
  import cxu_types::*;
#(
  parameter int CXU_ID     = 0,
  parameter int NUM_STATES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cxu_req_valid,
  output logic                          cxu_req_ready,
  input  logic [C_M_CXU_REQ_ID_W-1:0]   cxu_req_id,
  input  logic [C_M_CXU_CXU_ID_W-1:0]   cxu_req_cxu,
  input  logic [C_M_CXU_STATE_ID_W-1:0] cxu_req_state,
  input  logic [C_M_CXU_FUNC_ID_W-1:0]  cxu_req_func,
  input  logic [C_M_CXU_INSN_W-1:0]     cxu_req_insn,
  input  logic [C_M_CXU_DATA_W-1:0]     cxu_req_data0,
  input  logic [C_M_CXU_DATA_W-1:0]     cxu_req_data1,
  output logic                          cxu_resp_valid,
  input  logic                          cxu_resp_ready,
  output logic [C_M_CXU_REQ_ID_W-1:0]   cxu_resp_id,
  output logic [C_M_CXU_STATUS_W-1:0]   cxu_resp_status,
  output logic [C_M_CXU_DATA_W-1:0]     cxu_resp_data
);

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  localparam int DW = C_M_CXU_DATA_W;
  localparam int SW = C_M_CXU_STATE_ID_W;

  state_t state_reg, state_next;

  logic [C_M_CXU_REQ_ID_W-1:0]  id_reg;
  logic [C_M_CXU_FUNC_ID_W-1:0] func_reg;
  logic [SW-1:0]                sel_reg;
  logic [C_M_CXU_REQ_ID_W-1:0]  resp_id_reg, resp_id_next;
  logic [C_M_CXU_STATUS_W-1:0]  resp_status_reg, resp_status_next;
  logic [DW-1:0]                resp_data_reg, resp_data_next;

  logic [DW-1:0] acc_reg [NUM_STATES];
  logic          acc_we;
  logic [SW-1:0] acc_wsel;
  logic [DW-1:0] acc_wdata;
  logic [DW-1:0] acc_rd_req;
  logic [DW-1:0] acc_rd_sel;

  logic          accept;
  logic          req_err;
  logic          mul_start;
  logic          mul_done;
  logic [DW-1:0] mul_product;
  logic [DW-1:0] mac_sum;
  logic          unused_insn;

  // The raw instruction word carries nothing this unit decodes.
  assign unused_insn = ^cxu_req_insn;

  assign cxu_req_ready   = (state_reg == IDLE);
  assign cxu_resp_valid  = (state_reg == RESP);
  assign cxu_resp_id     = resp_id_reg;
  assign cxu_resp_status = resp_status_reg;
  assign cxu_resp_data   = resp_data_reg;
  assign accept          = cxu_req_valid && cxu_req_ready;

  assign req_err = (cxu_req_cxu != C_M_CXU_CXU_ID_W'(CXU_ID))
                || (cxu_req_func > CXU_FUNC_CLRACC)
                || (uses_acc(cxu_req_func) && (int'(cxu_req_state) >= NUM_STATES));

  assign mac_sum = acc_rd_sel + mul_product;

  // Accumulator read ports: one for the incoming request, one for the latched context.
  always_comb begin
    acc_rd_req = '0;
    acc_rd_sel = '0;
    for (int i = 0; i < NUM_STATES; i++) begin
      if (cxu_req_state == SW'(i)) acc_rd_req = acc_reg[i];
      if (sel_reg == SW'(i))       acc_rd_sel = acc_reg[i];
    end
  end

  cxu_serial_mul #(.W(DW)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (cxu_req_data0),
    .b       (cxu_req_data1),
    .done    (mul_done),
    .product (mul_product)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next state, response fields and accumulator write control.
  always_comb begin
    state_next       = state_reg;
    mul_start        = 1'b0;
    acc_we           = 1'b0;
    acc_wsel         = sel_reg;
    acc_wdata        = '0;
    resp_id_next     = resp_id_reg;
    resp_status_next = resp_status_reg;
    resp_data_next   = resp_data_reg;
    case (state_reg)
      IDLE: begin
        if (cxu_req_valid) begin
          if (req_err) begin
            state_next       = RESP;
            resp_id_next     = cxu_req_id;
            resp_status_next = CXU_STATUS_ERR;
            resp_data_next   = '0;
          end else if (cxu_req_func == CXU_FUNC_MUL || cxu_req_func == CXU_FUNC_MAC) begin
            state_next = MUL;
            mul_start  = 1'b1;
          end else begin
            state_next       = RESP;
            resp_id_next     = cxu_req_id;
            resp_status_next = CXU_STATUS_OK;
            if (cxu_req_func == CXU_FUNC_ADD) begin
              resp_data_next = cxu_req_data0 + cxu_req_data1;
            end else begin
              resp_data_next = acc_rd_req;
              if (cxu_req_func == CXU_FUNC_CLRACC) begin
                acc_we   = 1'b1;
                acc_wsel = cxu_req_state;
              end
            end
          end
        end
      end
      MUL: begin
        if (mul_done) begin
          state_next       = RESP;
          resp_id_next     = id_reg;
          resp_status_next = CXU_STATUS_OK;
          if (func_reg == CXU_FUNC_MAC) begin
            resp_data_next = mac_sum;
            acc_we         = 1'b1;
            acc_wdata      = mac_sum;
          end else begin
            resp_data_next = mul_product;
          end
        end
      end
      RESP: begin
        if (cxu_resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture on accept and registered response fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_reg          <= '0;
      func_reg        <= '0;
      sel_reg         <= '0;
      resp_id_reg     <= '0;
      resp_status_reg <= '0;
      resp_data_reg   <= '0;
    end else begin
      if (accept) begin
        id_reg   <= cxu_req_id;
        func_reg <= cxu_req_func;
        sel_reg  <= cxu_req_state;
      end
      resp_id_reg     <= resp_id_next;
      resp_status_reg <= resp_status_next;
      resp_data_reg   <= resp_data_next;
    end
  end

  // One accumulator register per context.
  generate
    for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_acc
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   acc_reg[gi] <= '0;
        else if (acc_we && (acc_wsel == SW'(gi)))  acc_reg[gi] <= acc_wdata;
      end
    end
  endgenerate

endmodule
